fib_calc: RTL and testbench

Iterative Fibonacci FSMD: accepts an 8-bit unsigned index n and computes fib(n) by repeated addition, one addition per clock. It sits directly downstream of the bcd_to_bin converter. Its `start` is driven by the converter's `done_tick`, and `n_in` by its `binary_value`. The result is clamped to F_MAX with an overflow flag, so it fits the 4-digit BCD display path downstream.

---
 rtl/fib_pkg.sv | 14 +
 rtl/fib_calc.sv | 95 +++++++++
 tb/tb_fib_calc.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// Shared types and default constants for the iterative Fibonacci calculator.
package fib_pkg;

  typedef enum logic [1:0] {
    idle,
    op,
    done
  } fib_state_t;

  localparam int unsigned FIB_N_W   = 8;
  localparam int unsigned FIB_F_W   = 14;
  localparam int unsigned FIB_F_MAX = 9999;

endpackage

// File: rtl/fib_calc.sv
// Iterative Fibonacci FSMD: one addition per clock, result saturates at F_MAX
// with an overflow flag so it always fits the 4-digit BCD display path.
module fib_calc
  import fib_pkg::*;
#(
  parameter int unsigned N_W   = FIB_N_W,
  parameter int unsigned F_W   = FIB_F_W,
  parameter int unsigned F_MAX = FIB_F_MAX
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N_W-1:0] n_in,
  output logic           ready,
  output logic           done_tick,
  output logic           overflow,
  output logic [F_W-1:0] fib_out
);

  localparam logic [F_W:0]   F_MAX_EXT = (F_W+1)'(F_MAX);
  localparam logic [N_W-1:0] N_ONE     = N_W'(1);

  fib_state_t     state_reg, state_next;
  logic [N_W-1:0] n_reg, n_next;
  logic [F_W-1:0] t0_reg, t0_next;
  logic [F_W-1:0] t1_reg, t1_next;
  logic           ovf_reg, ovf_next;
  logic [F_W:0]   sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= idle;
      n_reg     <= '0;
      t0_reg    <= '0;
      t1_reg    <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      n_reg     <= n_next;
      t0_reg    <= t0_next;
      t1_reg    <= t1_next;
      ovf_reg   <= ovf_next;
    end
  end

  // Sum is one bit wider than the operands so the saturation compare never wraps.
  assign sum = {1'b0, t0_reg} + {1'b0, t1_reg};

  always_comb begin
    state_next = state_reg;
    n_next     = n_reg;
    t0_next    = t0_reg;
    t1_next    = t1_reg;
    ovf_next   = ovf_reg;
    unique case (state_reg)
      idle: begin
        if (start) begin
          n_next     = n_in;
          t0_next    = '0;
          t1_next    = F_W'(1);
          ovf_next   = 1'b0;
          state_next = op;
        end
      end
      op: begin
        if (n_reg == '0) begin
          t1_next    = '0;
          state_next = done;
        end else if (n_reg == N_ONE) begin
          state_next = done;
        end else if (sum > F_MAX_EXT) begin
          t1_next    = F_W'(F_MAX);
          ovf_next   = 1'b1;
          state_next = done;
        end else begin
          t0_next = t1_reg;
          t1_next = sum[F_W-1:0];
          n_next  = n_reg - N_ONE;
        end
      end
      done: begin
        state_next = idle;
      end
      default: begin
        state_next = idle;
      end
    endcase
  end

  assign ready     = (state_reg == idle);
  assign done_tick = (state_reg == done);
  assign overflow  = ovf_reg;
  assign fib_out   = t1_reg;

endmodule

// File: tb/tb_fib_calc.sv
// Self-checking bench for fib_calc: directed cases plus random indices checked
// against a plain-arithmetic Fibonacci model with saturation and latency.
module tb_fib_calc;

  localparam int unsigned N_W   = 8;
  localparam int unsigned F_W   = 14;
  localparam int unsigned F_MAX = 9999;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [N_W-1:0] n_in;
  logic           ready;
  logic           done_tick;
  logic           overflow;
  logic [F_W-1:0] fib_out;

  int checks = 0;
  int errors = 0;

  fib_calc #(.N_W(N_W), .F_W(F_W), .F_MAX(F_MAX)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .n_in      (n_in),
    .ready     (ready),
    .done_tick (done_tick),
    .overflow  (overflow),
    .fib_out   (fib_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: value, overflow flag and done_tick cycle number for index n.
  function automatic void ref_fib(input int n, output int val, output bit ovf, output int lat);
    int a, b, c;
    a = 0; b = 1; ovf = 0;
    if (n == 0) begin val = 0; lat = 2; return; end
    if (n == 1) begin val = 1; lat = 2; return; end
    for (int i = 2; i <= n; i++) begin
      c = a + b;
      if (c > int'(F_MAX)) begin
        val = int'(F_MAX); ovf = 1; lat = i;
        return;
      end
      a = b; b = c;
    end
    val = b; lat = n + 1;
  endfunction

  // Runs one request; p1/p2 are cycles with an extra start pulse, rst_cyc a cycle with reset (0 = none).
  task automatic run_case(input int n, input int p1, input int p2, input int rst_cyc);
    int  exp_val, exp_lat, dones, done_cyc;
    bit  exp_ovf;
    logic [F_W-1:0] held_val;
    logic           held_ovf;
    ref_fib(n, exp_val, exp_ovf, exp_lat);
    dones = 0; done_cyc = 0;
    n_in  = N_W'(n);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_in  = N_W'($urandom);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      reset = (cyc == rst_cyc);
      start = (cyc == p1) || (cyc == p2);
      if (cyc == 1) check("ready_low_in_op", ready, 0);
      if (done_tick) begin
        dones++;
        done_cyc = cyc;
        check($sformatf("fib_out n=%0d", n), fib_out, exp_val);
        check($sformatf("overflow n=%0d", n), overflow, exp_ovf);
      end
      if (rst_cyc != 0 && cyc == rst_cyc + 1) begin
        check("ready_after_reset", ready, 1);
        check("fib_out_after_reset", fib_out, 0);
        check("overflow_after_reset", overflow, 0);
      end
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b0;
    reset = 1'b0;
    if (rst_cyc == 0) begin
      check($sformatf("done_count n=%0d", n), dones, 1);
      check($sformatf("latency n=%0d", n), done_cyc, exp_lat);
      check("ready_idle", ready, 1);
      check("fib_out_held", fib_out, exp_val);
      check("overflow_held", overflow, exp_ovf);
      held_val = fib_out;
      held_ovf = overflow;
    end else begin
      check("done_count_reset", dones, 0);
    end
  endtask

  initial begin
    int rn;
    reset = 1'b1;
    start = 1'b0;
    n_in  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_ready", ready, 1);
    check("reset_fib_out", fib_out, 0);
    check("reset_overflow", overflow, 0);
    check("reset_done_tick", done_tick, 0);

    run_case(0, 0, 0, 0);
    run_case(1, 0, 0, 0);
    run_case(2, 0, 0, 0);
    run_case(10, 0, 0, 0);
    run_case(20, 0, 0, 0);
    run_case(21, 0, 0, 0);
    run_case(99, 0, 0, 0);
    run_case(5, 0, 0, 0);
    run_case(10, 3, 11, 0);
    run_case(15, 0, 0, 6);
    run_case(7, 0, 0, 0);
    run_case(255, 0, 0, 0);

    for (int k = 0; k < 30; k++) begin
      rn = (k % 3 == 0) ? int'($urandom_range(255, 0)) : int'($urandom_range(24, 0));
      run_case(rn, 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
